// File: rtl/chain_relax_core.sv
// chain_relax_core: Gauss-Seidel smoothing of a chain of 2-D node positions, one node per clock
module chain_relax_core #(
    parameter int NODES    = 5,
    parameter int W        = 32,
    parameter int PASSES   = 4,
    parameter int HAS_PREV = 1,
    parameter int HAS_NEXT = 1,
    parameter int IW       = $clog2(NODES),
    parameter int PCW      = $clog2(PASSES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                init_we_i,
    input  logic [IW-1:0]       init_idx_i,
    input  logic signed [W-1:0] init_x_i,
    input  logic signed [W-1:0] init_y_i,
    input  logic signed [W-1:0] prev_core_last_x_i,
    input  logic signed [W-1:0] prev_core_last_y_i,
    input  logic signed [W-1:0] next_core_first_x_i,
    input  logic signed [W-1:0] next_core_first_y_i,
    input  logic [IW-1:0]       rd_idx_i,
    output logic signed [W-1:0] rd_x_o,
    output logic signed [W-1:0] rd_y_o,
    output logic signed [W-1:0] first_x_o,
    output logic signed [W-1:0] first_y_o,
    output logic signed [W-1:0] last_x_o,
    output logic signed [W-1:0] last_y_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [PCW-1:0]      pass_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [PCW-1:0]      pass_q, pass_d;
    logic signed [W-1:0] x_q [NODES];
    logic signed [W-1:0] y_q [NODES];

    logic                first_node, last_node, node_we, load_we;
    logic [IW-1:0]       l_idx, r_idx;
    logic signed [W-1:0] lx, ly, rx, ry, nx, ny;

    // (L + 2C + R) >>> 2 in W+2 bits; the result always lies within the input range
    function automatic logic signed [W-1:0] relax(input logic signed [W-1:0] l, c, r);
        logic [W+1:0] s;
        s = {{2{l[W-1]}}, l} + {c[W-1], c, 1'b0} + {{2{r[W-1]}}, r};
        return s[W+1:2];
    endfunction

    // neighbour selection and new position for the node under the pointer
    always_comb begin
        first_node = ptr_q == '0;
        last_node  = ptr_q == IW'(NODES - 1);
        l_idx      = first_node ? ptr_q : ptr_q - 1'b1;
        r_idx      = last_node ? ptr_q : ptr_q + 1'b1;
        lx         = first_node ? prev_core_last_x_i : x_q[l_idx];
        ly         = first_node ? prev_core_last_y_i : y_q[l_idx];
        rx         = last_node ? next_core_first_x_i : x_q[r_idx];
        ry         = last_node ? next_core_first_y_i : y_q[r_idx];
        nx         = relax(lx, x_q[ptr_q], rx);
        ny         = relax(ly, y_q[ptr_q], ry);
        node_we    = state_q == RUN && !(first_node && HAS_PREV == 0)
                     && !(last_node && HAS_NEXT == 0);
        load_we    = state_q == IDLE && init_we_i && ({1'b0, init_idx_i} < (IW + 1)'(NODES));
    end

    // next-state logic: pointer sweep, pass counting and run/done sequencing
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                ptr_d   = '0;
                pass_d  = '0;
            end
            RUN: begin
                ptr_d  = last_node ? '0 : ptr_q + 1'b1;
                pass_d = last_node ? pass_q + 1'b1 : pass_q;
                if (last_node && pass_q == PCW'(PASSES - 1))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // control state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pass_q  <= pass_d;
        end
    end

    // node register file: loaded in IDLE, relaxed in place during RUN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NODES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NODES; i++) begin
                if (load_we && init_idx_i == IW'(i)) begin
                    x_q[i] <= init_x_i;
                    y_q[i] <= init_y_i;
                end else if (node_we && ptr_q == IW'(i)) begin
                    x_q[i] <= nx;
                    y_q[i] <= ny;
                end
            end
        end
    end

    assign rd_x_o       = x_q[rd_idx_i];
    assign rd_y_o       = y_q[rd_idx_i];
    assign first_x_o    = x_q[0];
    assign first_y_o    = y_q[0];
    assign last_x_o     = x_q[NODES-1];
    assign last_y_o     = y_q[NODES-1];
    assign busy_o       = state_q == RUN;
    assign done_o       = state_q == DONE;
    assign pass_count_o = pass_q;
endmodule

// File: tb/tb_chain_relax_core.sv
// tb_chain_relax_core: directed checks on three core configurations sharing load/boundary inputs
module tb_chain_relax_core;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic               start [3];
    logic               init_we = 0;
    logic [2:0]         init_idx = 0;
    logic signed [31:0] init_x = 0, init_y = 0;
    logic signed [31:0] prev_x = 0, prev_y = 0, next_x = 0, next_y = 0;
    logic [2:0]         rd_idx = 0;
    logic signed [31:0] rd_x [3], rd_y [3], fx [3], fy [3], lx [3], ly [3];
    logic               busy [3], done [3];
    logic [2:0]         pc_a;
    logic               pc_b, pc_c;
    int checks = 0, fails = 0;

    chain_relax_core #(.NODES(5), .W(32), .PASSES(4), .HAS_PREV(0), .HAS_NEXT(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .init_we_i(init_we), .init_idx_i(init_idx),
        .init_x_i(init_x), .init_y_i(init_y), .prev_core_last_x_i(prev_x), .prev_core_last_y_i(prev_y),
        .next_core_first_x_i(next_x), .next_core_first_y_i(next_y), .rd_idx_i(rd_idx),
        .rd_x_o(rd_x[0]), .rd_y_o(rd_y[0]), .first_x_o(fx[0]), .first_y_o(fy[0]), .last_x_o(lx[0]),
        .last_y_o(ly[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_count_o(pc_a));

    chain_relax_core #(.NODES(5), .W(32), .PASSES(1), .HAS_PREV(0), .HAS_NEXT(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .init_we_i(init_we), .init_idx_i(init_idx),
        .init_x_i(init_x), .init_y_i(init_y), .prev_core_last_x_i(prev_x), .prev_core_last_y_i(prev_y),
        .next_core_first_x_i(next_x), .next_core_first_y_i(next_y), .rd_idx_i(rd_idx),
        .rd_x_o(rd_x[1]), .rd_y_o(rd_y[1]), .first_x_o(fx[1]), .first_y_o(fy[1]), .last_x_o(lx[1]),
        .last_y_o(ly[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_count_o(pc_b));

    chain_relax_core #(.NODES(5), .W(32), .PASSES(1), .HAS_PREV(1), .HAS_NEXT(1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .init_we_i(init_we), .init_idx_i(init_idx),
        .init_x_i(init_x), .init_y_i(init_y), .prev_core_last_x_i(prev_x), .prev_core_last_y_i(prev_y),
        .next_core_first_x_i(next_x), .next_core_first_y_i(next_y), .rd_idx_i(rd_idx),
        .rd_x_o(rd_x[2]), .rd_y_o(rd_y[2]), .first_x_o(fx[2]), .first_y_o(fy[2]), .last_x_o(lx[2]),
        .last_y_o(ly[2]), .busy_o(busy[2]), .done_o(done[2]), .pass_count_o(pc_c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int x, input int y);
        init_we = 1; init_idx = 3'(idx); init_x = x; init_y = y;
        tick;
        init_we = 0;
    endtask

    task automatic run(input int d, output int edges, output int bc);
        start[d] = 1;
        tick;
        start[d] = 0;
        edges = 0; bc = 0;
        while (!done[d] && edges < 200) begin
            if (busy[d]) bc++;
            tick;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick; tick;
        rst_n = 1;
        tick;
        for (int i = 0; i < 5; i++) begin
            rd_idx = 3'(i);
            #1;
            checks++;
            if (rd_x[0] !== 0 || rd_y[0] !== 0) begin
                fails++; $display("FAIL reset_node%0d got x=%0d y=%0d want 0,0", i, rd_x[0], rd_y[0]);
            end
        end
        checks++;
        if (busy[0] !== 0 || done[0] !== 0 || pc_a !== 0) begin
            fails++; $display("FAIL reset_ctrl got busy=%b done=%b pc=%0d want 0,0,0", busy[0], done[0], pc_a);
        end
    endtask

    task automatic test_linear(input string tag);
        int edges, bc;
        for (int i = 0; i < 5; i++) load(i, 4 * i, 0);
        run(0, edges, bc);
        checks++;
        if (edges !== 20 || bc !== 20) begin
            fails++; $display("FAIL %s_timing got edges=%0d busy_cycles=%0d want 20,20", tag, edges, bc);
        end
        checks++;
        if (busy[0] !== 0 || pc_a !== 3'd4) begin
            fails++; $display("FAIL %s_done_state got busy=%b pc=%0d want 0,4", tag, busy[0], pc_a);
        end
        for (int i = 0; i < 5; i++) begin
            rd_idx = 3'(i);
            #1;
            checks++;
            if (rd_x[0] !== 4 * i || rd_y[0] !== 0) begin
                fails++; $display("FAIL %s_node%0d got x=%0d y=%0d want %0d,0", tag, i, rd_x[0], rd_y[0], 4 * i);
            end
        end
        tick;
        checks++;
        if (done[0] !== 0 || pc_a !== 3'd4) begin
            fails++; $display("FAIL %s_pulse got done=%b pc=%0d want 0,4", tag, done[0], pc_a);
        end
    endtask

    task automatic test_single_pass;
        int edges, bc;
        int ex[5] = '{0, 2, 4, 1, 0};
        int ey[5] = '{-1, -1, -1, -1, 0};
        for (int i = 0; i < 5; i++) load(i, (i == 2) ? 8 : 0, (i == 0) ? -1 : 0);
        run(1, edges, bc);
        checks++;
        if (edges !== 5 || pc_b !== 1'b1) begin
            fails++; $display("FAIL single_timing got edges=%0d pc=%0d want 5,1", edges, pc_b);
        end
        for (int i = 0; i < 5; i++) begin
            rd_idx = 3'(i);
            #1;
            checks++;
            if (rd_x[1] !== ex[i] || rd_y[1] !== ey[i]) begin
                fails++; $display("FAIL single_node%0d got x=%0d y=%0d want %0d,%0d", i, rd_x[1], rd_y[1], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_upstream;
        int edges, bc;
        int ex[5] = '{25, 6, 1, 0, 0};
        for (int i = 0; i < 5; i++) load(i, 0, 0);
        prev_x = 100; prev_y = 0; next_x = 0; next_y = 0;
        run(2, edges, bc);
        checks++;
        if (edges !== 5 || fx[2] !== 25 || lx[2] !== 0) begin
            fails++; $display("FAIL upstream_ends got edges=%0d first=%0d last=%0d want 5,25,0", edges, fx[2], lx[2]);
        end
        for (int i = 0; i < 5; i++) begin
            rd_idx = 3'(i);
            #1;
            checks++;
            if (rd_x[2] !== ex[i] || rd_y[2] !== 0) begin
                fails++; $display("FAIL upstream_node%0d got x=%0d y=%0d want %0d,0", i, rd_x[2], rd_y[2], ex[i]);
            end
        end
        prev_x = 0;
    endtask

    task automatic test_ignored;
        int edges, bc;
        for (int i = 0; i < 5; i++) load(i, 4 * i, 0);
        start[0] = 1;
        tick;
        start[0] = 0;
        tick; tick; tick;
        start[0] = 1; init_we = 1; init_idx = 3'd2; init_x = 99; init_y = 0;
        tick;
        start[0] = 0; init_we = 0;
        edges = 4;
        while (!done[0] && edges < 200) begin
            tick;
            edges++;
        end
        checks++;
        if (edges !== 20) begin
            fails++; $display("FAIL ignored_timing got edges=%0d want 20", edges);
        end
        rd_idx = 3'd2;
        #1;
        checks++;
        if (rd_x[0] !== 8) begin
            fails++; $display("FAIL ignored_node2 got x=%0d want 8", rd_x[0]);
        end
        tick;
        checks++;
        if (done[0] !== 0 || busy[0] !== 0) begin
            fails++; $display("FAIL ignored_after got done=%b busy=%b want 0,0", done[0], busy[0]);
        end
        tick;
        checks++;
        if (done[0] !== 0 || busy[0] !== 0) begin
            fails++; $display("FAIL ignored_norestart got done=%b busy=%b want 0,0", done[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) load(i, 4 * i + 3, -7);
        start[0] = 1;
        tick;
        start[0] = 0;
        for (int i = 0; i < 7; i++) tick;
        checks++;
        if (busy[0] !== 1 || pc_a !== 3'd1) begin
            fails++; $display("FAIL midrun_state got busy=%b pc=%0d want 1,1", busy[0], pc_a);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (busy[0] !== 0 || done[0] !== 0 || pc_a !== 0) begin
            fails++; $display("FAIL midreset_ctrl got busy=%b done=%b pc=%0d want 0,0,0", busy[0], done[0], pc_a);
        end
        for (int i = 0; i < 5; i++) begin
            rd_idx = 3'(i);
            #1;
            checks++;
            if (rd_x[0] !== 0 || rd_y[0] !== 0) begin
                fails++; $display("FAIL midreset_node%0d got x=%0d y=%0d want 0,0", i, rd_x[0], rd_y[0]);
            end
        end
        rst_n = 1;
        tick;
        test_linear("post_reset");
    endtask

    initial begin
        start = '{0, 0, 0};
        test_reset;
        test_linear("linear");
        test_single_pass;
        test_upstream;
        test_ignored;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
